// File: rtl/demux_rr_sched8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_sched_pkg
//  Brief    : Shared constants, state encoding and helpers for demux_rr_sched8
//  Revision : 1.0
// ============================================================================
package demux_sched_pkg;

    localparam int NUM_DEST = 8;
    localparam int SEL_W    = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last-served pointer starts at 7 so the first search begins at destination 0
    localparam logic [SEL_W-1:0] c_ptr_rst = 3'd7;

    function automatic logic [NUM_DEST-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return NUM_DEST'(1) << idx;
    endfunction

endpackage : demux_sched_pkg
`default_nettype wire

// File: rtl/demux_rr_sched8_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_rr_sched8_if
//  Brief    : Source / destination bus of the round-robin demux scheduler
//  Revision : 1.0
// ============================================================================
interface demux_rr_sched8_if
    import demux_sched_pkg::*;
#(
    parameter int DW = 1
);
    logic                en;
    logic                in_valid;
    logic [DW-1:0]       in_data;
    logic                in_ready;
    logic [NUM_DEST-1:0] dest_ready;
    logic [SEL_W-1:0]    sel;
    logic                grant_valid;
    logic [NUM_DEST-1:0] out_valid;
    logic [DW-1:0]       out_data;

    // Scheduler side
    modport master (
        input  en, in_valid, in_data, dest_ready,
        output in_ready, sel, grant_valid, out_valid, out_data
    );

    // Source and destination side
    modport slave (
        output en, in_valid, in_data, dest_ready,
        input  in_ready, sel, grant_valid, out_valid, out_data
    );
endinterface : demux_rr_sched8_if
`default_nettype wire

// File: rtl/demux_rr_sched8_rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick8
//  Brief    : Rotating-priority finder; first request after 'last', wrapping
//  Revision : 1.0
// ============================================================================
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [NUM_DEST-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [SEL_W-1:0]    pick,
    output logic                any
);

    // Scan from farthest to nearest so the nearest request after 'last' wins
    always_comb begin
        pick = '0;
        any  = |req;
        for (int i = NUM_DEST; i >= 1; i--) begin
            if (req[last + SEL_W'(i)]) begin
                pick = last + SEL_W'(i);
            end
        end
    end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/demux_rr_sched8.sv
`default_nettype none
// ============================================================================
//  Module   : demux_rr_sched8
//  Brief    : Round-robin burst scheduler driving a 1-to-8 demux
//  Revision : 1.0
// ============================================================================
module demux_rr_sched8
    import demux_sched_pkg::*;
#(
    parameter int DW    = 1,
    parameter int BURST = 4
)(
    input  logic               clk,
    input  logic               rst,
    demux_rr_sched8_if.master  bus
);

    localparam logic [7:0] c_last_beat = 8'(BURST - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_cur;
    logic [7:0]          r_beat;
    logic [NUM_DEST-1:0] r_out_valid;
    logic [DW-1:0]       r_out_data;

    logic [SEL_W-1:0]    w_pick;
    logic                w_any;
    logic                w_cur_rdy;
    logic                w_in_ready;
    logic                w_grant_valid;
    logic                w_xfer;
    logic                w_last;
    logic                w_arb;
    logic                w_release;

    rr_pick8 u_pick (
        .req  (bus.dest_ready),
        .last (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

    assign w_cur_rdy = bus.dest_ready[r_cur];
    assign w_xfer    = bus.in_valid & w_in_ready;
    assign w_last    = (r_beat == c_last_beat);
    assign w_arb     = (r_state == IDLE)  && (w_state_nxt == GRANT);
    assign w_release = (r_state == GRANT) && (w_state_nxt == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.en && w_any) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A ready drop releases without a transfer since in_ready is low
                if ((w_xfer && w_last) || (bus.en && !w_cur_rdy)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // in_ready is masked by rst so an item offered during reset is never taken
    always_comb begin
        w_in_ready    = 1'b0;
        w_grant_valid = 1'b0;
        if (r_state == GRANT) begin
            w_grant_valid = 1'b1;
            w_in_ready    = bus.en & w_cur_rdy & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= c_ptr_rst;
            r_cur       <= '0;
            r_beat      <= '0;
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_xfer ? onehot8(r_cur) : '0;
            if (w_xfer) begin
                r_out_data <= bus.in_data;
                r_beat     <= r_beat + 8'd1;
            end
            if (w_arb) begin
                r_cur  <= w_pick;
                r_beat <= '0;
            end
            if (w_release) begin
                r_ptr <= r_cur;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.grant_valid = w_grant_valid;
    assign bus.sel         = r_cur;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;

endmodule : demux_rr_sched8
`default_nettype wire

// File: tb/tb_demux_rr_sched8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_rr_sched8
//  Brief    : Directed self-checking bench for demux_rr_sched8 (DW=8, BURST=4)
//  Revision : 1.0
// ============================================================================
module tb_demux_rr_sched8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    demux_rr_sched8_if #(.DW(8)) bus ();

    demux_rr_sched8 #(.DW(8), .BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic       en;
        logic       iv;
        logic [7:0] d;
        logic [7:0] dr;
        logic       ir;
        logic [2:0] sel;
        logic       gv;
        logic [7:0] ov;
        logic [7:0] od;
        logic       chk_od;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at edge+1: apply inputs, check in_ready mid-cycle, advance to next edge+1
    task automatic cyc(input logic e, input logic iv, input logic [7:0] d,
                       input logic [7:0] dr, input logic exp_ir, input string nm);
        bus.en         = e;
        bus.in_valid   = iv;
        bus.in_data    = d;
        bus.dest_ready = dr;
        #3;
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'(exp_ir));
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string nm, input logic [2:0] s, input logic g,
                        input logic [7:0] ov, input logic [7:0] od, input logic chk_od);
        chk({nm, "_sel"},         32'(bus.sel),         32'(s));
        chk({nm, "_grant_valid"}, 32'(bus.grant_valid), 32'(g));
        chk({nm, "_out_valid"},   32'(bus.out_valid),   32'(ov));
        if (chk_od) chk({nm, "_out_data"}, 32'(bus.out_data), 32'(od));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         order [4];
        logic [7:0] dd;

        // en iv  d      dr     ir sel gv  ov     od     chk_od
        tbl[0]  = '{1, 0, 8'h00, 8'h08, 0, 3, 1, 8'h00, 8'h00, 0};
        tbl[1]  = '{1, 1, 8'h11, 8'h08, 1, 3, 1, 8'h08, 8'h11, 1};
        tbl[2]  = '{1, 1, 8'h22, 8'h08, 1, 3, 1, 8'h08, 8'h22, 1};
        tbl[3]  = '{1, 1, 8'h33, 8'h50, 0, 3, 0, 8'h00, 8'h22, 1};
        tbl[4]  = '{1, 0, 8'h44, 8'h50, 0, 4, 1, 8'h00, 8'h22, 1};
        tbl[5]  = '{1, 0, 8'h00, 8'h40, 0, 4, 0, 8'h00, 8'h22, 1};
        tbl[6]  = '{1, 0, 8'h00, 8'h40, 0, 6, 1, 8'h00, 8'h22, 1};
        tbl[7]  = '{1, 1, 8'hA5, 8'h40, 1, 6, 1, 8'h40, 8'hA5, 1};
        tbl[8]  = '{1, 1, 8'h3C, 8'h40, 1, 6, 1, 8'h40, 8'h3C, 1};
        tbl[9]  = '{1, 0, 8'h99, 8'h40, 1, 6, 1, 8'h00, 8'h3C, 1};
        tbl[10] = '{1, 1, 8'hFF, 8'h40, 1, 6, 1, 8'h40, 8'hFF, 1};
        tbl[11] = '{1, 1, 8'h5A, 8'h40, 1, 6, 0, 8'h40, 8'h5A, 1};
        tbl[12] = '{0, 1, 8'h00, 8'h40, 0, 6, 0, 8'h00, 8'h5A, 1};
        order   = '{5, 7, 2, 5};

        rst = 1'b1;
        bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.dest_ready = '0;
        @(posedge clk);
        #1;
        cyc(0, 0, 8'h00, 8'h00, 0, "reset");
        post("reset", 3'd0, 0, 8'h00, 8'h00, 1);
        rst = 1'b0;

        // Round robin across all destinations and wrap back to 0
        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, 8'hE0, 8'hFF, 0, "rr_arb");
            post("rr_arb", 3'(k % 8), 1, 8'h00, 8'h00, 0);
            for (int j = 0; j < 4; j++) begin
                dd = 8'(k * 16 + j);
                cyc(1, 1, dd, 8'hFF, 1, "rr_beat");
                post("rr_beat", 3'(k % 8), (j < 3), 8'(1 << (k % 8)), dd, 1);
            end
        end

        // Enable freeze after one beat on destination 1
        cyc(1, 0, 8'h00, 8'hFF, 0, "frz_arb");
        post("frz_arb", 3'd1, 1, 8'h00, 8'h00, 0);
        cyc(1, 1, 8'h51, 8'hFF, 1, "frz_b0");
        post("frz_b0", 3'd1, 1, 8'h02, 8'h51, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'(8'h60 + i), 8'hFF, 0, "frz_hold");
            post("frz_hold", 3'd1, 1, 8'h00, 8'h51, 1);
        end
        for (int j = 0; j < 3; j++) begin
            cyc(1, 1, 8'(8'h70 + j), 8'hFF, 1, "frz_resume");
            post("frz_resume", 3'd1, (j < 2), 8'h02, 8'(8'h70 + j), 1);
        end
        cyc(0, 1, 8'h00, 8'hFF, 0, "frz_after");
        post("frz_after", 3'd1, 0, 8'h00, 8'h72, 1);

        // Park ptr at 2 via a ready-drop release on destination 2
        cyc(1, 0, 8'h00, 8'hFF, 0, "p2_arb");
        post("p2_arb", 3'd2, 1, 8'h00, 8'h00, 0);
        cyc(1, 0, 8'h00, 8'h00, 0, "p2_drop");
        post("p2_drop", 3'd2, 0, 8'h00, 8'h00, 0);

        // Skip not-ready destinations
        for (int g = 0; g < 4; g++) begin
            cyc(1, 1, 8'h00, 8'hA4, 0, "skip_arb");
            post("skip_arb", 3'(order[g]), 1, 8'h00, 8'h00, 0);
            for (int j = 0; j < 4; j++) begin
                dd = 8'(8'h80 + g * 4 + j);
                cyc(1, 1, dd, 8'hA4, 1, "skip_beat");
                post("skip_beat", 3'(order[g]), (j < 3), 8'(1 << order[g]), dd, 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 8'h00, 8'h00, 0, "none_ready");
            post("none_ready", 3'd5, 0, 8'h00, 8'h00, 0);
        end

        // Ready drop mid-burst and data latency vectors
        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].iv, tbl[i].d, tbl[i].dr, tbl[i].ir, $sformatf("vec%0d", i));
            post($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gv, tbl[i].ov, tbl[i].od, tbl[i].chk_od);
        end

        // Reset in the middle of a burst on destination 2
        cyc(1, 0, 8'h00, 8'h04, 0, "rm_arb");
        post("rm_arb", 3'd2, 1, 8'h00, 8'h00, 0);
        cyc(1, 1, 8'hB1, 8'h04, 1, "rm_b0");
        post("rm_b0", 3'd2, 1, 8'h04, 8'hB1, 1);
        cyc(1, 1, 8'hB2, 8'h04, 1, "rm_b1");
        post("rm_b1", 3'd2, 1, 8'h04, 8'hB2, 1);
        rst = 1'b1;
        cyc(1, 1, 8'hB3, 8'hFF, 0, "rm_rst");
        post("rm_rst", 3'd0, 0, 8'h00, 8'h00, 1);
        rst = 1'b0;
        cyc(1, 0, 8'h00, 8'hFF, 0, "rm_arb2");
        post("rm_arb2", 3'd0, 1, 8'h00, 8'h00, 1);
        cyc(1, 1, 8'hC1, 8'hFF, 1, "rm_beat");
        post("rm_beat", 3'd0, 1, 8'h01, 8'hC1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_rr_sched8
`default_nettype wire

// File: doc/demux_rr_sched8.md
Name: demux_rr_sched8

Overview:
- Controller that shares one input stream among 8 destinations through a 1-to-8 demultiplexer.
- Grants destinations in round-robin order, skipping destinations that are not ready.
- Holds each grant for a burst of up to BURST transfers.
- Drives the demux select and a one-hot registered valid, and back-pressures the source with in_ready.

Parameters:
- DW, 1, data width carried through the demux.
- BURST, 4, maximum transfers per grant before rotating (1..255).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  scheduler enable; 0 freezes arbitration and transfers
- in_valid  input  1  source has a data item
- in_data  input  DW  source data
- in_ready  output  1  source item accepted this cycle when in_valid & in_ready
- dest_ready  input  8  per-destination ready; bit i = destination i can take data
- sel  output  3  demux select = currently/last granted destination
- grant_valid  output  1  a grant is active (state GRANT)
- out_valid  output  8  registered one-hot strobe: bit sel high for one cycle per transferred item
- out_data  output  DW  registered data accompanying out_valid

Behaviour:
- Reset (rst=1 at clk edge, regardless of state):
  - state=IDLE, ptr=7 (last served, so the first pick is 0), cur=0, beat_cnt=0.
  - sel=0, grant_valid=0, out_valid=0, out_data=0.
  - in_ready is 0 during and after reset until a grant exists.
  - An in-flight burst is aborted; no strobe is produced for an item presented in the reset cycle.
- State IDLE:
  - in_ready=0, grant_valid=0.
  - If en and dest_ready!=0, pick = first set bit of dest_ready searching ptr+1, ptr+2, ... mod 8 (wrap 7->0).
  - Next cycle: state=GRANT, cur=pick, sel=pick, beat_cnt=0.
  - The arbitration costs exactly one cycle; with dest_ready=0 or en=0, stay in IDLE.
- State GRANT:
  - grant_valid=1.
  - in_ready = en & dest_ready[cur] (combinational).
  - Transfer = in_valid & in_ready. On the next edge: out_valid = one-hot(cur), out_data=in_data, beat_cnt+1. Latency in->out is 1 cycle.
  - Otherwise out_valid=0 and out_data holds its last value.
  - Release to IDLE with ptr<=cur on either of:
    - a transfer with beat_cnt==BURST-1;
    - en=1 & dest_ready[cur]=0 (the destination dropped ready; no transfer occurs that cycle).
  - en=0 in GRANT: hold cur and beat_cnt, no transfer, no release.
- sel holds its value in IDLE; it changes only on entry to GRANT.
- Single ready destination: it is re-granted after each release, with a 1-cycle IDLE gap between bursts.
- Simultaneous transfer on the last beat and dest_ready drop cannot occur, because a transfer requires ready.
- out_valid is never multi-hot; it is all-zero outside transfer strobes.
- BURST=1 means every transfer releases.
- beat_cnt width is 8 bits, compared against BURST-1 (no wrap within a burst).

Decomposition:
- Package demux_sched_pkg holds:
  - NUM_DEST=8, SEL_W=3;
  - the state enum {IDLE, GRANT};
  - the ptr reset constant 3'd7.
- One combinational sub-module rr_pick8:
  - Inputs: req[7:0], last[2:0].
  - Outputs: pick[2:0], any.
  - Rotate-priority finder; the parent instantiates it in IDLE decode.

Test Plan:
1. Reset mid-burst:
   - Stimulus: grant active on dest 2 with beat_cnt=2, assert rst for 1 cycle with in_valid=1.
   - Required: out_valid=0, sel=0, grant_valid=0, in_ready=0 next cycle; the first grant after reset goes to dest 0 when dest_ready=8'hFF.
2. Round-robin order with BURST=4:
   - Stimulus: dest_ready=8'hFF, in_valid always 1.
   - Required: strobes out_valid=01,01,01,01 (dest0) then 1 idle cycle, then 02 x4, 04 x4 ... 80 x4, then wraps to 01; no output on idle cycles.
3. Skip not-ready destinations:
   - Stimulus: dest_ready=8'b1010_0100, ptr=2.
   - Required: grant order 5,7,2,5.
   - Stimulus: dest_ready=0.
   - Required: stays IDLE, in_ready=0 indefinitely.
4. Ready drop mid-burst:
   - Stimulus: grant on dest 3, after 2 transfers drop dest_ready[3].
   - Required: in_ready=0 that cycle, state returns to IDLE, next grant goes to the next ready destination after 3; exactly 2 strobes on bit 3.
5. Enable freeze:
   - Stimulus: en=0 for 5 cycles in GRANT after 1 beat.
   - Required: no strobes, sel unchanged; after en=1 the burst completes with exactly 3 more beats (BURST=4).
6. Data path latency:
   - Stimulus: in_data sequence A5,3C,FF (DW=8) on dest 6.
   - Required: out_data=A5,3C,FF with out_valid=8'h40, each one cycle after its accept.
